// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width and ALU op encodings {funct7[5], funct3}.
package cpu_pkg;
  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
endpackage

// File: rtl/alu.sv
// Registered integer ALU: result appears on rd the cycle after rs1/rs2/op are presented.
module alu #(
  parameter int XLEN = cpu_pkg::XLEN
) (
  input  logic            clk,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [3:0]      op,
  output logic [XLEN-1:0] rd
);
  import cpu_pkg::*;

  localparam int SHW = $clog2(XLEN);

  logic signed [XLEN-1:0] rs1_s, rs2_s;
  logic        [SHW-1:0]  shamt;
  logic        [XLEN-1:0] rd_d;

  assign rs1_s = rs1;
  assign rs2_s = rs2;
  assign shamt = rs2[SHW-1:0];

  // Reserved encodings fall through to ADD.
  always_comb begin
    rd_d = rs1 + rs2;
    case (op)
      ALU_SUB:  rd_d = rs1 - rs2;
      ALU_SLL:  rd_d = rs1 << shamt;
      ALU_SLT:  rd_d = {{(XLEN-1){1'b0}}, (rs1_s < rs2_s)};
      ALU_SLTU: rd_d = {{(XLEN-1){1'b0}}, (rs1 < rs2)};
      ALU_XOR:  rd_d = rs1 ^ rs2;
      ALU_SRL:  rd_d = rs1 >> shamt;
      ALU_SRA:  rd_d = $unsigned(rs1_s >>> shamt);
      ALU_OR:   rd_d = rs1 | rs2;
      ALU_AND:  rd_d = rs1 & rs2;
      default:  rd_d = rs1 + rs2;
    endcase
  end

  always_ff @(posedge clk) begin
    rd <= rd_d;
  end
endmodule

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter; on a tie the port not granted most recently wins.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] eligible,
  output logic [1:0] grant
);
  logic last_grant_q, last_grant_d;

  always_comb begin
    grant        = 2'b00;
    last_grant_d = last_grant_q;
    case (eligible)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
    if (grant != 2'b00) last_grant_d = grant[1];
  end

  // Reset to port 1 so port 0 takes the first tie.
  always_ff @(posedge clk) begin
    if (reset) last_grant_q <= 1'b1;
    else       last_grant_q <= last_grant_d;
  end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between the execute stage (port 0) and the address/branch
// helper (port 1); each port has at most one op outstanding and a held response register.
module alu_arbiter #(
  parameter int XLEN = cpu_pkg::XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_rs1,
  input  logic [XLEN-1:0] req0_rs2,
  input  logic [3:0]      req0_op,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_rs1,
  input  logic [XLEN-1:0] req1_rs2,
  input  logic [3:0]      req1_op,
  output logic            resp0_valid,
  input  logic            resp0_ready,
  output logic [XLEN-1:0] resp0_rd,
  output logic            resp1_valid,
  input  logic            resp1_ready,
  output logic [XLEN-1:0] resp1_rd,
  output logic [XLEN-1:0] alu_rs1,
  output logic [XLEN-1:0] alu_rs2,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_rd
);
  import cpu_pkg::*;

  logic [1:0]      inflight_q, inflight_d;
  logic [1:0]      resp_valid_q, resp_valid_d;
  logic [XLEN-1:0] resp0_rd_q, resp0_rd_d, resp1_rd_q, resp1_rd_d;
  logic [1:0]      eligible, grant;

  // Eligibility uses registered state only; nothing is granted while reset is high.
  assign eligible = {req1_valid & ~inflight_q[1] & ~resp_valid_q[1],
                     req0_valid & ~inflight_q[0] & ~resp_valid_q[0]} & {2{~reset}};

  rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .eligible (eligible),
    .grant    (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_comb begin
    alu_rs1 = '0;
    alu_rs2 = '0;
    alu_op  = ALU_ADD;
    if (grant[0]) begin
      alu_rs1 = req0_rs1;
      alu_rs2 = req0_rs2;
      alu_op  = req0_op;
    end else if (grant[1]) begin
      alu_rs1 = req1_rs1;
      alu_rs2 = req1_rs2;
      alu_op  = req1_op;
    end
  end

  always_comb begin
    inflight_d   = grant;
    resp_valid_d = inflight_q | (resp_valid_q & ~{resp1_ready, resp0_ready});
    resp0_rd_d   = inflight_q[0] ? alu_rd : resp0_rd_q;
    resp1_rd_d   = inflight_q[1] ? alu_rd : resp1_rd_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q   <= '0;
      resp_valid_q <= '0;
      resp0_rd_q   <= '0;
      resp1_rd_q   <= '0;
    end else begin
      inflight_q   <= inflight_d;
      resp_valid_q <= resp_valid_d;
      resp0_rd_q   <= resp0_rd_d;
      resp1_rd_q   <= resp1_rd_d;
    end
  end

  assign resp0_valid = resp_valid_q[0];
  assign resp1_valid = resp_valid_q[1];
  assign resp0_rd    = resp0_rd_q;
  assign resp1_rd    = resp1_rd_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter wired to alu; a scoreboard queues expected results per port.
module tb_alu_arbiter;
  import cpu_pkg::*;

  localparam int W = 32;

  logic         clk, reset;
  logic         req0_valid, req1_valid, resp0_ready, resp1_ready;
  logic [W-1:0] req0_rs1, req0_rs2, req1_rs1, req1_rs2;
  logic [3:0]   req0_op, req1_op;
  logic         req0_ready, req1_ready, resp0_valid, resp1_valid;
  logic [W-1:0] resp0_rd, resp1_rd, alu_rs1, alu_rs2, alu_rd;
  logic [3:0]   alu_op;

  int           checks, errors;
  logic [W-1:0] q0[$], q1[$];

  alu_arbiter #(.XLEN(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rs1(req0_rs1),
    .req0_rs2(req0_rs2), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rs1(req1_rs1),
    .req1_rs2(req1_rs2), .req1_op(req1_op),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_rd(resp0_rd),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_rd(resp1_rd),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_op(alu_op), .alu_rd(alu_rd)
  );

  alu #(.XLEN(W)) u_alu (.clk(clk), .rs1(alu_rs1), .rs2(alu_rs2), .op(alu_op), .rd(alu_rd));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [3:0] op);
    case (op)
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return a + b;
    endcase
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_rs1 = '0; req0_rs2 = '0; req0_op = ALU_ADD;
    req1_valid = 0; req1_rs1 = '0; req1_rs2 = '0; req1_op = ALU_ADD;
    resp0_ready = 1; resp1_ready = 1;
  endtask

  task automatic apply_reset();
    reset = 1;
    next_cycle();
    next_cycle();
    reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    req0_valid = 1; req0_rs1 = 32'd5; req0_rs2 = 32'd6; req0_op = ALU_SUB;
    req1_valid = 1; req1_rs1 = 32'd7; req1_rs2 = 32'd8; req1_op = ALU_XOR;
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready: got %b, expected 00", {req0_ready, req1_ready});
    end
    checks++;
    if ({resp0_valid, resp1_valid} !== 2'b00) begin
      errors++; $display("FAIL reset_resp_valid: got %b, expected 00", {resp0_valid, resp1_valid});
    end
    checks++;
    if (resp0_rd !== '0 || resp1_rd !== '0) begin
      errors++; $display("FAIL reset_resp_rd: got %h/%h, expected 0/0", resp0_rd, resp1_rd);
    end
    checks++;
    if (alu_op !== 4'd0 || alu_rs1 !== '0 || alu_rs2 !== '0) begin
      errors++; $display("FAIL reset_alu_in: got op %h rs1 %h rs2 %h, expected zeros", alu_op, alu_rs1, alu_rs2);
    end
    next_cycle();
    idle_inputs();
    reset = 0;
  endtask

  task automatic test_single();
    req0_valid = 1; req0_rs1 = 32'd4; req0_rs2 = 32'd3; req0_op = ALU_ADD;
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL single_grant: got r0r1=%b, expected 10", {req0_ready, req1_ready});
    end
    checks++;
    if (alu_rs1 !== 32'd4 || alu_rs2 !== 32'd3 || alu_op !== ALU_ADD) begin
      errors++; $display("FAIL single_alu_in: got %h %h op %h, expected 4 3 op 0", alu_rs1, alu_rs2, alu_op);
    end
    next_cycle();
    req0_valid = 0;
    @(negedge clk);
    checks++;
    if (resp0_valid !== 1'b0) begin
      errors++; $display("FAIL single_resp_early: got %b, expected 0", resp0_valid);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (resp0_valid !== 1'b1 || resp0_rd !== 32'd7) begin
      errors++; $display("FAIL single_resp: got valid %b rd %0d, expected 1 / 7", resp0_valid, resp0_rd);
    end
    checks++;
    if (resp1_valid !== 1'b0 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL single_port1_quiet: got resp1_valid %b req1_ready %b, expected 0 0", resp1_valid, req1_ready);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (resp0_valid !== 1'b0) begin
      errors++; $display("FAIL single_consumed: got %b, expected 0", resp0_valid);
    end
    next_cycle();
  endtask

  task automatic test_tie();
    apply_reset();
    req0_valid = 1; req0_rs1 = 32'd4; req0_rs2 = 32'd3; req0_op = ALU_SUB;
    req1_valid = 1; req1_rs1 = 32'd4; req1_rs2 = 32'd3; req1_op = ALU_SLL;
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL tie_first: got r0r1=%b, expected 10", {req0_ready, req1_ready});
    end
    next_cycle();
    req0_valid = 0;
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01 || alu_op !== ALU_SLL) begin
      errors++; $display("FAIL tie_second: got r0r1=%b op %h, expected 01 op 1", {req0_ready, req1_ready}, alu_op);
    end
    next_cycle();
    req1_valid = 0;
    @(negedge clk);
    checks++;
    if (resp0_valid !== 1'b1 || resp0_rd !== 32'd1 || resp1_valid !== 1'b0) begin
      errors++; $display("FAIL tie_resp0: got v0 %b rd0 %0d v1 %b, expected 1 1 0", resp0_valid, resp0_rd, resp1_valid);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (resp1_valid !== 1'b1 || resp1_rd !== 32'd32) begin
      errors++; $display("FAIL tie_resp1: got v1 %b rd1 %0d, expected 1 32", resp1_valid, resp1_rd);
    end
    next_cycle();
  endtask

  task automatic test_fairness();
    int prev, n0, n1, last0, last1;
    prev = -1; n0 = 0; n1 = 0; last0 = -1; last1 = -1;
    apply_reset();
    req0_valid = 1; req0_rs1 = 32'd10;   req0_rs2 = 32'd20;   req0_op = ALU_ADD;
    req1_valid = 1; req1_rs1 = 32'h0F0;  req1_rs2 = 32'h0FF;  req1_op = ALU_XOR;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        checks++;
        if (req0_ready && req1_ready) begin
          errors++; $display("FAIL fair_onehot: got both ready at cycle %0d, expected one", i);
        end else if (req0_ready !== ((prev == -1) || (prev == 1))) begin
          errors++; $display("FAIL fair_alternate: got port %0d after port %0d at cycle %0d, expected the other", req0_ready ? 0 : 1, prev, i);
        end
        if (req0_ready) begin
          if (last0 != -1) begin
            checks++;
            if (i - last0 > 3) begin
              errors++; $display("FAIL fair_gap0: got gap %0d, expected <= 3", i - last0);
            end
          end
          last0 = i; n0++; prev = 0;
        end else begin
          if (last1 != -1) begin
            checks++;
            if (i - last1 > 3) begin
              errors++; $display("FAIL fair_gap1: got gap %0d, expected <= 3", i - last1);
            end
          end
          last1 = i; n1++; prev = 1;
        end
      end
      next_cycle();
    end
    checks++;
    if (n0 != 4 || n1 != 4) begin
      errors++; $display("FAIL fair_count: got %0d/%0d grants, expected 4/4", n0, n1);
    end
    idle_inputs();
    repeat (3) next_cycle();
  endtask

  task automatic test_backpressure();
    int n0;
    n0 = 0;
    apply_reset();
    req1_valid = 1; req1_rs1 = 32'd3; req1_rs2 = 32'd4; req1_op = ALU_SLTU;
    resp1_ready = 0;
    @(negedge clk);
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++; $display("FAIL bp_grant: got req1_ready %b, expected 1", req1_ready);
    end
    next_cycle();
    next_cycle();
    req0_valid = 1; req0_rs1 = 32'd1; req0_rs2 = 32'd1; req0_op = ALU_ADD;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (resp1_valid !== 1'b1 || resp1_rd !== 32'd1 || req1_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold: cycle %0d got v1 %b rd1 %0d r1 %b, expected 1 1 0", i, resp1_valid, resp1_rd, req1_ready);
      end
      if (req0_ready) n0++;
      next_cycle();
    end
    checks++;
    if (n0 != 2) begin
      errors++; $display("FAIL bp_port0_grants: got %0d, expected 2", n0);
    end
    resp1_ready = 1; req1_valid = 0; req0_valid = 0;
    next_cycle();
    @(negedge clk);
    checks++;
    if (resp1_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release: got resp1_valid %b, expected 0", resp1_valid);
    end
    repeat (3) next_cycle();
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    req0_valid = 1; req0_rs1 = 32'd9; req0_rs2 = 32'd9; req0_op = ALU_ADD;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_grant: got req0_ready %b, expected 1", req0_ready);
    end
    next_cycle();
    req0_valid = 0;
    reset = 1;
    next_cycle();
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (resp0_valid !== 1'b0) begin
        errors++; $display("FAIL rst_mid_discard: cycle %0d got resp0_valid %b, expected 0", i, resp0_valid);
      end
      next_cycle();
    end
    req0_valid = 1; req0_rs1 = 32'd6; req0_rs2 = 32'd3; req0_op = ALU_OR;
    req1_valid = 1; req1_rs1 = 32'd6; req1_rs2 = 32'd3; req1_op = ALU_AND;
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL rst_mid_tie: got r0r1=%b, expected 10", {req0_ready, req1_ready});
    end
    next_cycle();
    req0_valid = 0;
    next_cycle();
    req1_valid = 0;
    repeat (3) next_cycle();
  endtask

  task automatic test_reserved();
    req0_valid = 1; req0_rs1 = 32'd10; req0_rs2 = 32'd5; req0_op = 4'b1001;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1 || alu_op !== 4'b1001) begin
      errors++; $display("FAIL reserved_issue: got ready %b op %h, expected 1 op 9", req0_ready, alu_op);
    end
    next_cycle();
    req0_valid = 0;
    repeat (3) next_cycle();
  endtask

  task automatic test_idle();
    idle_inputs();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (alu_op !== 4'd0 || alu_rs1 !== '0 || alu_rs2 !== '0) begin
        errors++; $display("FAIL idle_alu_in: cycle %0d got op %h rs1 %h rs2 %h, expected zeros", i, alu_op, alu_rs1, alu_rs2);
      end
      checks++;
      if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0) begin
        errors++; $display("FAIL idle_resp: cycle %0d got %b%b, expected 00", i, resp0_valid, resp1_valid);
      end
      next_cycle();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1;
    idle_inputs();
    fork
      forever begin
        logic [W-1:0] exp_v;
        @(negedge clk);
        if (reset) begin
          q0.delete();
          q1.delete();
        end else begin
          if (req0_valid && req0_ready) q0.push_back(model(req0_rs1, req0_rs2, req0_op));
          if (req1_valid && req1_ready) q1.push_back(model(req1_rs1, req1_rs2, req1_op));
          if (resp0_valid && resp0_ready) begin
            checks++;
            if (q0.size() == 0) begin
              errors++; $display("FAIL sb_resp0: got rd %h, expected no response", resp0_rd);
            end else begin
              exp_v = q0.pop_front();
              if (resp0_rd !== exp_v) begin
                errors++; $display("FAIL sb_resp0: got rd %h, expected %h", resp0_rd, exp_v);
              end
            end
          end
          if (resp1_valid && resp1_ready) begin
            checks++;
            if (q1.size() == 0) begin
              errors++; $display("FAIL sb_resp1: got rd %h, expected no response", resp1_rd);
            end else begin
              exp_v = q1.pop_front();
              if (resp1_rd !== exp_v) begin
                errors++; $display("FAIL sb_resp1: got rd %h, expected %h", resp1_rd, exp_v);
              end
            end
          end
        end
      end
    join_none

    test_reset();
    test_single();
    test_tie();
    test_fairness();
    test_backpressure();
    test_reset_midflight();
    test_reserved();
    test_idle();

    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++; $display("FAIL sb_drain: got %0d/%0d outstanding, expected 0/0", q0.size(), q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
